// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-issue logic: ARM condition codes,
// NZCV bit positions and the issue FSM state encoding.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: decides whether an instruction
// with condition field `cond` executes under flags `nzcv`.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = nzcv[NZCV_N];
    assign z = nzcv[NZCV_Z];
    assign c = nzcv[NZCV_C];
    assign v = nzcv[NZCV_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            // NV is architecturally "never"
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_issue_ctrl.sv
// Issue-stage controller: owns NZCV, evaluates the ID instruction's condition
// against forwarded or architectural flags and stalls behind in-flight setters.
module cond_issue_ctrl
    import cond_pkg::*;
#(
    parameter int FLAG_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             id_set_flags,
    output logic             id_ready,
    output logic             iss_valid,
    output logic             iss_exec,
    output logic             iss_set_flags,
    input  logic             fw_valid,
    input  logic [3:0]       fw_flags,
    input  logic             flush,
    output logic [3:0]       status,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int PW = $clog2(FLAG_LAT + 1);

    logic [PW-1:0] pend_cnt;
    state_t        state;
    state_t        state_next;
    logic [3:0]    eff;
    logic          pass;
    logic          flag_hazard;
    logic          cap_hazard;
    logic          hazard;
    logic          issue;
    logic          setter_issued;

    assign eff = fw_valid ? fw_flags : status;

    cond_eval u_cond_eval (
        .cond (id_cond),
        .nzcv (eff),
        .pass (pass)
    );

    // A writer retiring this cycle is forwarded, so only writers beyond it block.
    assign flag_hazard = id_valid && (id_cond != COND_AL) &&
                         ((pend_cnt > PW'(1)) || ((pend_cnt == PW'(1)) && !fw_valid));
    assign cap_hazard  = id_valid && id_set_flags &&
                         (pend_cnt == PW'(FLAG_LAT)) && !fw_valid;
    assign hazard      = flag_hazard || cap_hazard;

    always_comb begin
        id_ready   = 1'b0;
        issue      = 1'b0;
        state_next = state;
        if (!rst_n) begin
            state_next = ST_RUN;
        end else if (flush) begin
            id_ready   = 1'b1;
            state_next = ST_FLUSH;
        end else begin
            case (state)
                ST_RUN: begin
                    id_ready = !hazard;
                    issue    = id_valid && !hazard;
                    if (hazard) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    id_ready = !hazard;
                    issue    = id_valid && !hazard;
                    if (!hazard) begin
                        state_next = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    id_ready   = 1'b1;
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    assign setter_issued = issue && pass && id_set_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            status        <= 4'b0000;
            pend_cnt      <= '0;
            iss_valid     <= 1'b0;
            iss_exec      <= 1'b0;
            iss_set_flags <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            state         <= state_next;
            iss_valid     <= issue;
            iss_exec      <= issue && pass;
            iss_set_flags <= setter_issued;
            if (fw_valid) begin
                status <= fw_flags;
            end
            if (flush) begin
                pend_cnt <= '0;
            end else if (setter_issued && !fw_valid) begin
                pend_cnt <= pend_cnt + PW'(1);
            end else if (!setter_issued && fw_valid && (pend_cnt != '0)) begin
                pend_cnt <= pend_cnt - PW'(1);
            end
            if ((state == ST_WAIT) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    // A forward with nothing outstanding means upstream lost track of a writer.
    assert property (@(posedge clk) disable iff (!rst_n) !(fw_valid && (pend_cnt == '0)));

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Self-checking bench for cond_issue_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_cond_issue_ctrl;

    localparam int FLAG_LAT = 2;
    localparam int CNT_W    = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [3:0]       id_cond;
    logic             id_set_flags;
    logic             id_ready;
    logic             iss_valid;
    logic             iss_exec;
    logic             iss_set_flags;
    logic             fw_valid;
    logic [3:0]       fw_flags;
    logic             flush;
    logic [3:0]       status;
    logic [CNT_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: flags, outstanding-writer count, stall count, and
    // whether the previous cycle left an instruction blocked or was a flush.
    logic [3:0] m_status;
    int         m_pend;
    int         m_stall;
    bit         m_waiting;
    bit         m_flushing;
    bit         m_iv;
    bit         m_ie;
    bit         m_is;
    logic       last_ready;

    always #5 clk = ~clk;

    cond_issue_ctrl #(
        .FLAG_LAT (FLAG_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_cond       (id_cond),
        .id_set_flags  (id_set_flags),
        .id_ready      (id_ready),
        .iss_valid     (iss_valid),
        .iss_exec      (iss_exec),
        .iss_set_flags (iss_set_flags),
        .fw_valid      (fw_valid),
        .fw_flags      (fw_flags),
        .flush         (flush),
        .status        (status),
        .stall_cycles  (stall_cycles)
    );

    // ARM encoding: cond[3:1] picks a base test, cond[0] inverts it (AL/NV pair included).
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n;
        bit z;
        bit cf;
        bit v;
        bit base;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input bit rst, input bit v, input logic [3:0] c, input bit sf,
                                  input bit fw, input logic [3:0] fwf, input bit fl);
        bit         haz;
        bit         issue;
        bit         p;
        bit         ready_exp;
        logic [3:0] eff;
        int         inc;
        @(negedge clk);
        rst_n        = !rst;
        id_valid     = v;
        id_cond      = c;
        id_set_flags = sf;
        fw_valid     = fw;
        fw_flags     = fwf;
        flush        = fl;
        #1;
        eff = fw ? fwf : m_status;
        // Blocked if a writer is still outstanding after this cycle's forward,
        // or if a new setter would exceed the in-flight limit.
        haz = v && (((c != 4'hE) && ((m_pend - int'(fw)) > 0)) ||
                    (sf && (m_pend == FLAG_LAT) && !fw));
        if (rst)
            ready_exp = 1'b0;
        else if (fl || m_flushing)
            ready_exp = 1'b1;
        else
            ready_exp = !haz;
        check_output("id_ready", {15'd0, id_ready}, {15'd0, ready_exp});
        last_ready = id_ready;
        issue = !rst && !fl && !m_flushing && v && !haz;
        p = ref_pass(c, eff);
        if (rst) begin
            m_status   = 4'b0000;
            m_pend     = 0;
            m_stall    = 0;
            m_waiting  = 1'b0;
            m_flushing = 1'b0;
            m_iv       = 1'b0;
            m_ie       = 1'b0;
            m_is       = 1'b0;
        end else begin
            if (m_waiting && (m_stall < STALL_MAX))
                m_stall++;
            inc = (issue && p && sf) ? 1 : 0;
            if (fl) begin
                m_pend = 0;
            end else begin
                m_pend = m_pend + inc - int'(fw);
                if (m_pend < 0)
                    m_pend = 0;
            end
            if (fw)
                m_status = fwf;
            m_iv       = issue;
            m_ie       = issue && p;
            m_is       = issue && p && sf;
            m_waiting  = !fl && !m_flushing && haz;
            m_flushing = fl;
        end
        @(posedge clk);
        #1;
        check_output("iss_valid", {15'd0, iss_valid}, {15'd0, m_iv});
        check_output("iss_exec", {15'd0, iss_exec}, {15'd0, m_ie});
        check_output("iss_set_flags", {15'd0, iss_set_flags}, {15'd0, m_is});
        check_output("status", {12'd0, status}, {12'd0, m_status});
        check_output("stall_cycles", {12'd0, stall_cycles}, 16'(m_stall));
        check_output("pend_cnt", 16'(dut.pend_cnt), 16'(m_pend));
    endtask

    task automatic do_reset();
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic issue_subs();
        apply_stimulus(1'b0, 1'b1, 4'hE, 1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        bit         cur_v;
        logic [3:0] cur_c;
        bit         cur_sf;
        bit         r_fw;
        bit         r_fl;
        bit         r_rst;
        rst_n        = 1'b0;
        id_valid     = 1'b0;
        id_cond      = 4'h0;
        id_set_flags = 1'b0;
        fw_valid     = 1'b0;
        fw_flags     = 4'h0;
        flush        = 1'b0;
        last_ready   = 1'b0;

        // Reset values
        do_reset();
        check_output("reset_status", {12'd0, status}, 16'h0);
        check_output("reset_iss_valid", {15'd0, iss_valid}, 16'h0);

        // Forwarded Z=1 lets EQ issue in the same cycle as the forward
        issue_subs();
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b0);
        check_output("t1_status", {12'd0, status}, 16'h4);
        check_output("t1_iss_exec", {15'd0, iss_exec}, 16'h1);

        // SUBS then EQ: one WAIT cycle, released by fw Z=1
        do_reset();
        issue_subs();
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        check_output("t2_wait_ready", {15'd0, last_ready}, 16'h0);
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b0);
        check_output("t2_iss_exec", {15'd0, iss_exec}, 16'h1);
        check_output("t2_stall", {12'd0, stall_cycles}, 16'h1);

        // Same with Z=0: EQ setter is nullified and does not count as a writer
        do_reset();
        issue_subs();
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b0);
        check_output("t3_iss_valid", {15'd0, iss_valid}, 16'h1);
        check_output("t3_iss_exec", {15'd0, iss_exec}, 16'h0);
        check_output("t3_iss_sf", {15'd0, iss_set_flags}, 16'h0);
        check_output("t3_pend", 16'(dut.pend_cnt), 16'h0);

        // Three back-to-back setters: the third hits the capacity limit
        do_reset();
        issue_subs();
        issue_subs();
        issue_subs();
        check_output("t4_cap_ready", {15'd0, last_ready}, 16'h0);
        apply_stimulus(1'b0, 1'b1, 4'hE, 1'b1, 1'b1, 4'b0010, 1'b0);
        check_output("t4_release_ready", {15'd0, last_ready}, 16'h1);
        check_output("t4_pend", 16'(dut.pend_cnt), 16'h2);

        // Flush during WAIT with a simultaneous forward
        do_reset();
        issue_subs();
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'b1001, 1'b1);
        check_output("t5_iss_valid", {15'd0, iss_valid}, 16'h0);
        check_output("t5_status", {12'd0, status}, 16'h9);
        check_output("t5_pend", 16'(dut.pend_cnt), 16'h0);
        apply_stimulus(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0);
        check_output("t5_flush_ready", {15'd0, last_ready}, 16'h1);
        check_output("t5_flush_no_issue", {15'd0, iss_valid}, 16'h0);
        apply_stimulus(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0);
        check_output("t5_run_issue", {15'd0, iss_valid}, 16'h1);

        // Sweep every condition against every flag value held in status
        do_reset();
        for (int f = 0; f < 16; f++) begin
            issue_subs();
            apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'(f), 1'b0);
            for (int c = 0; c < 16; c++) begin
                apply_stimulus(1'b0, 1'b1, 4'(c), 1'b0, 1'b0, 4'h0, 1'b0);
                if (c >= 14)
                    check_output("sweep_al_nv", {15'd0, iss_exec}, {15'd0, (c == 14)});
            end
        end

        // Long stall drives the counter to saturation
        do_reset();
        issue_subs();
        for (int i = 0; i < 20; i++)
            apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        check_output("sat_stall", {12'd0, stall_cycles}, 16'(STALL_MAX));
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b0);
        check_output("sat_hold", {12'd0, stall_cycles}, 16'(STALL_MAX));

        // Random traffic; a stalled instruction stays in ID until accepted
        do_reset();
        cur_v  = 1'b0;
        cur_c  = 4'h0;
        cur_sf = 1'b0;
        r_fl   = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r_rst = ($urandom_range(99) < 2);
            if (!(cur_v && !last_ready && !r_fl)) begin
                cur_v  = ($urandom_range(99) < 80);
                cur_c  = 4'($urandom_range(15));
                cur_sf = cur_v && ($urandom_range(99) < 40);
            end
            r_fw = (m_pend > 0) && ($urandom_range(1) == 1);
            r_fl = ($urandom_range(99) < 5);
            apply_stimulus(r_rst, cur_v, cur_c, cur_sf, r_fw, 4'($urandom_range(15)), r_fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
